// File: rtl/ac_pkg.sv
// ac_pkg: state encoding and mode constants shared by the actuator sequencer.
package ac_pkg;
    typedef enum logic [2:0] {IDLE, PRE, HEAT, COOL, POST} state_t;
    typedef enum logic {MODE_HEAT, MODE_COOL} mode_t;
endpackage

// File: rtl/ac_cycle_timer.sv
// ac_cycle_timer: loadable down-counter; done is registered and high while the count is zero.
module ac_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            done <= (load_val == '0);
        end else if (!done) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CNT_W'(1));
        end
    end
endmodule

// File: rtl/ac_actuator_seq.sv
// ac_actuator_seq: fan/heater/compressor sequencing with pre/post fan run, min run and compressor lockout.
module ac_actuator_seq
    import ac_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PRE_CYC  = 4,
    parameter int POST_CYC = 6,
    parameter int MIN_RUN  = 10,
    parameter int MIN_OFF  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic heating,
    input  logic cooling,
    output logic fan_en,
    output logic heater_en,
    output logic comp_en,
    output logic lockout,
    output logic req_err
);
    state_t           state, state_d;
    mode_t            mode;
    logic [CNT_W-1:0] run, st_val;
    logic             heat_req, cool_req, req_on, st_load, st_done, off_done;
    logic             fan_d, heater_d, comp_d;
    assign heat_req = heating & ~cooling;
    assign cool_req = cooling & ~heating;
    assign req_on   = (mode == MODE_HEAT) ? heat_req : cool_req;
    assign lockout  = ~off_done;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode  <= MODE_HEAT;
        end else begin
            state <= state_d;
            if (state == IDLE && state_d == PRE)
                mode <= heat_req ? MODE_HEAT : MODE_COOL;
        end
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (heat_req || (cool_req && !lockout)) state_d = PRE;
            PRE:        state_d = !req_on ? POST : st_done ? ((mode == MODE_HEAT) ? HEAT : COOL) : PRE;
            HEAT, COOL: if (!req_on && run >= CNT_W'(MIN_RUN - 1)) state_d = POST;
            POST:       if (st_done) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end
    // Outputs follow the next state so each drive changes on the same edge as the state.
    always_comb begin
        fan_d    = (state_d != IDLE);
        heater_d = (state_d == HEAT);
        comp_d   = (state_d == COOL);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fan_en    <= 1'b0;
            heater_en <= 1'b0;
            comp_en   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            fan_en    <= fan_d;
            heater_en <= heater_d;
            comp_en   <= comp_d;
            if (heating && cooling) req_err <= 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  run <= '0;
        else if (state_d != state) run <= '0;
        else if (run != '1)        run <= run + 1'b1;
    end
    assign st_load = (state_d != state) && (state_d == PRE || state_d == POST);
    assign st_val  = (state_d == PRE) ? CNT_W'(PRE_CYC - 1) : CNT_W'(POST_CYC - 1);
    ac_cycle_timer #(.CNT_W(CNT_W)) u_state_tmr (
        .clk(clk), .rst(rst), .load(st_load), .load_val(st_val), .done(st_done)
    );
    ac_cycle_timer #(.CNT_W(CNT_W)) u_off_tmr (
        .clk(clk), .rst(rst), .load(comp_en & ~comp_d), .load_val(CNT_W'(MIN_OFF)), .done(off_done)
    );
endmodule

// File: tb/tb_ac_actuator_seq.sv
// tb_ac_actuator_seq: directed scenario tasks with hand-computed cycle windows for each drive.
module tb_ac_actuator_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic heating = 1'b0;
    logic cooling = 1'b0;
    logic fan_en, heater_en, comp_en, lockout, req_err;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    ac_actuator_seq dut (
        .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
        .fan_en(fan_en), .heater_en(heater_en), .comp_en(comp_en),
        .lockout(lockout), .req_err(req_err)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic test_reset();
        logic [4:0] act;
        do_reset();
        act = {fan_en, heater_en, comp_en, lockout, req_err};
        n_cmp++;
        if (act !== 5'b0) begin
            $display("FAIL reset_outs got %b exp 00000", act);
            n_bad++;
        end
    endtask
    // cycle c: state of the drives in the interval after edge c; inputs set before the step belong to cycle c-1
    task automatic test_heat();
        logic [3:0] act, exp;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            heating = (c - 1) < 8;
            step();
            act = {fan_en, heater_en, comp_en, lockout};
            exp = {c >= 1 && c <= 20, c >= 5 && c <= 14, 1'b0, 1'b0};
            n_cmp++;
            if (act !== exp) begin
                $display("FAIL heat c=%0d got %b exp %b", c, act, exp);
                n_bad++;
            end
        end
    endtask
    task automatic test_cool_lockout();
        logic [3:0] act, exp;
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            cooling = ((c - 1) < 30) || ((c - 1) >= 37);
            step();
            act = {fan_en, heater_en, comp_en, lockout};
            exp = {(c <= 36) || (c >= 52), 1'b0, (c >= 5 && c <= 30) || c >= 56, c >= 31 && c <= 50};
            n_cmp++;
            if (act !== exp) begin
                $display("FAIL cool_lock c=%0d got %b exp %b", c, act, exp);
                n_bad++;
            end
        end
    endtask
    task automatic test_pre_abort();
        logic [3:0] act, exp;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            heating = (c - 1) < 2;
            step();
            act = {fan_en, heater_en, comp_en, lockout};
            exp = {c <= 8, 3'b000};
            n_cmp++;
            if (act !== exp) begin
                $display("FAIL pre_abort c=%0d got %b exp %b", c, act, exp);
                n_bad++;
            end
        end
    endtask
    task automatic test_req_err();
        logic [3:0] act;
        do_reset();
        heating = 1'b1;
        cooling = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            heating = 1'b0;
            cooling = 1'b0;
            act = {fan_en, heater_en, comp_en, req_err};
            n_cmp++;
            if (act !== 4'b0001) begin
                $display("FAIL req_err c=%0d got %b exp 0001", c, act);
                n_bad++;
            end
        end
        do_reset();
        n_cmp++;
        if (req_err !== 1'b0) begin
            $display("FAIL req_err_clear got %b exp 0", req_err);
            n_bad++;
        end
    endtask
    task automatic test_swap();
        logic [3:0] act, exp;
        do_reset();
        for (int c = 1; c <= 36; c++) begin
            heating = (c - 1) < 20;
            cooling = (c - 1) >= 20;
            step();
            act = {fan_en, heater_en, comp_en, lockout};
            exp = {c <= 26 || c >= 28, c >= 5 && c <= 20, c >= 32, 1'b0};
            n_cmp++;
            if (act !== exp || (heater_en && comp_en)) begin
                $display("FAIL swap c=%0d got %b exp %b", c, act, exp);
                n_bad++;
            end
        end
    endtask
    task automatic test_async_reset();
        logic [3:0] act;
        do_reset();
        cooling = 1'b1;
        repeat (8) step();
        act = {fan_en, heater_en, comp_en, lockout};
        n_cmp++;
        if (act !== 4'b1010) begin
            $display("FAIL async_pre got %b exp 1010", act);
            n_bad++;
        end
        #2 rst = 1'b1;
        #1 act = {fan_en, heater_en, comp_en, lockout};
        n_cmp++;
        if (act !== 4'b0000) begin
            $display("FAIL async_cool got %b exp 0000", act);
            n_bad++;
        end
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            cooling = (c - 1) < 10;
            step();
        end
        n_cmp++;
        if ({comp_en, lockout} !== 2'b01) begin
            $display("FAIL async_lock_pre got %b exp 01", {comp_en, lockout});
            n_bad++;
        end
        #2 rst = 1'b1;
        #1 act = {fan_en, heater_en, comp_en, lockout};
        n_cmp++;
        if (act !== 4'b0000) begin
            $display("FAIL async_lock got %b exp 0000", act);
            n_bad++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cooling = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            act = {fan_en, heater_en, comp_en, lockout};
            n_cmp++;
            if (act !== {1'b1, 1'b0, c >= 5, 1'b0}) begin
                $display("FAIL async_restart c=%0d got %b exp %b", c, act, {1'b1, 1'b0, c >= 5, 1'b0});
                n_bad++;
            end
        end
    endtask
    initial begin
        test_reset();
        test_heat();
        test_cool_lockout();
        test_pre_abort();
        test_req_err();
        test_swap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ac_actuator_seq.md
Name: ac_actuator_seq

Overview:
Downstream stage of the air-conditioning controller. It consumes the heating/cooling request levels and drives the physical actuators: fan, heater element and cooling compressor. It sequences fan pre-run and post-run, enforces a minimum run time, and applies a compressor minimum-off lockout. It also flags illegal simultaneous requests.

Parameters:
CNT_W, 16, width of the internal cycle counters
PRE_CYC, 4, fan-only cycles before the heater or compressor is enabled (1..2^CNT_W-1)
POST_CYC, 6, fan-only cycles after the heater or compressor is disabled (1..2^CNT_W-1)
MIN_RUN, 10, minimum cycles the heater or compressor stays enabled once on (1..2^CNT_W-1)
MIN_OFF, 20, minimum cycles the compressor stays off after being disabled (1..2^CNT_W-1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
heating  input  1  heat request level from the AC controller
cooling  input  1  cool request level from the AC controller
fan_en  output  1  fan drive
heater_en  output  1  heater element drive
comp_en  output  1  compressor drive
lockout  output  1  high while the compressor minimum-off timer is running
req_err  output  1  sticky; set when heating and cooling are both sampled high

Behaviour:
- All outputs are registered. On rst, every output is 0, the state is IDLE, all counters are 0 and the off-timer is expired. Reset takes effect immediately, including mid-run; drives drop without any post-run.
- Request decode: heat_req = heating & ~cooling; cool_req = cooling & ~heating.
  - Both high counts as no request and sets req_err. req_err clears only on rst.
- States: IDLE, PRE, HEAT, COOL, POST.
- IDLE: all drives 0.
  - heat_req sampled: go to PRE with mode=HEAT.
  - cool_req sampled with lockout=0: go to PRE with mode=COOL.
  - cool_req with lockout=1: stay in IDLE until lockout clears, then start.
- PRE: fan_en=1 for exactly PRE_CYC cycles. fan_en rises on the cycle after the request is first sampled.
  - If the request for the latched mode drops during PRE, go to POST; heater/compressor are never enabled.
  - Otherwise, after PRE_CYC cycles go to HEAT or COOL.
- HEAT: fan_en=1, heater_en=1. COOL: fan_en=1, comp_en=1.
  - The run counter starts at 0 on entry and saturates.
  - Exit to POST on the first edge where the mode's request is low and run count >= MIN_RUN-1, i.e. at least MIN_RUN enabled cycles.
  - An opposite request counts as the current request being low. No direct HEAT<->COOL transition.
- POST: fan_en=1, heater_en=0, comp_en=0 for exactly POST_CYC cycles, then IDLE.
  - A new request during POST is ignored until IDLE is reached.
- Lockout: on the cycle comp_en falls, the off-timer loads MIN_OFF and lockout=1.
  - The timer decrements each cycle; lockout=0 once it reaches 0, so lockout is high for exactly MIN_OFF cycles.
  - It runs independently of state; heating is never blocked by lockout.
- heater_en and comp_en are never both 1. fan_en is 1 whenever either is 1.
- Counters: state counter is CNT_W bits, reloaded on every state entry; run counter saturates at 2^CNT_W-1.

Decomposition:
- Package ac_pkg: state encoding (IDLE, PRE, HEAT, COOL, POST) and a mode constant (HEAT/COOL).
- One sub-module, ac_cycle_timer: CNT_W-bit loadable down-counter with load, load_val and done outputs.
  - Instantiated for the state timer and for the compressor off-timer.
- The run counter and FSM stay in the top module.

Test Plan:
- Reset then heating=1 held: fan_en rises at cycle 1, heater_en at cycle 5. Drop heating at cycle 8: heater_en stays high until 10 enabled cycles complete, then falls; fan_en stays high 6 more cycles, then 0.
- cooling=1 for 30 cycles then 0, then cooling=1 again immediately after POST: lockout high for exactly 20 cycles from the comp_en fall. The second PRE starts only the cycle after lockout clears.
- heating pulse of 2 cycles: PRE is aborted, heater_en never rises. fan_en is high for the pulse plus 6 POST cycles, then 0.
- heating=1 and cooling=1 together for 1 cycle: req_err=1 and stays 1 until rst. No actuator is enabled from IDLE.
- In HEAT after 15 cycles, swap to cooling=1/heating=0: sequence is HEAT to POST (6 cycles) to IDLE to PRE to COOL. heater_en and comp_en are never high together.
- Assert rst during COOL: fan_en, comp_en and lockout are 0 asynchronously. After release, cooling=1 starts PRE with no lockout delay.
